// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, transmitter state encoding and
// frame-bit helpers, used by both the keyboard transmitter and the receiver.
package ps2_pkg;

  localparam logic [7:0]  BREAK_CODE = 8'hF0;
  localparam int unsigned FRAME_BITS = 11;
  localparam logic [3:0]  LAST_BIT   = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } ps2_state_e;

  // Odd parity bit: set when the data byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Bit idx (0 = start) of the 11-bit frame carrying data.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic b;
    case (idx)
      4'd0:    b = 1'b0;
      4'd1:    b = data[0];
      4'd2:    b = data[1];
      4'd3:    b = data[2];
      4'd4:    b = data[3];
      4'd5:    b = data[4];
      4'd6:    b = data[5];
      4'd7:    b = data[6];
      4'd8:    b = data[7];
      4'd9:    b = odd_parity(data);
      default: b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_tx_timer.sv
// Loadable down-counter shared by the half-period and inter-frame gap timing.
// tc is high while the count sits at zero; the controller reloads on tc, so in
// active states it behaves as a one-cycle terminal-count pulse. The counter
// saturates at zero rather than wrapping.
module ps2_tx_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == {W{1'b0}});

  // Next count: load wins, otherwise decrement toward zero and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!tc) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// PS/2 keyboard-side transmitter: sends one make-code frame, or a break
// prefix frame (0xF0) followed by the make-code frame, each followed by an
// idle gap. PS2Data only changes on entry to BIT_HI, so it is stable for a
// full half-period on both sides of every PS2Clk falling edge.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 5000,
  parameter int unsigned GAP_CYCLES  = 10000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] scancode,
  input  logic       send_release,
  input  logic       send_valid,
  output logic       send_ready,
  output logic       PS2Clk,
  output logic       PS2Data
);

  localparam int unsigned MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] HP_LOAD  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  ps2_state_e  state_q,   state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  data_q,    data_d;     // byte of the frame in flight
  logic [7:0]  scan_q,    scan_d;     // make code held for the second frame
  logic        rel_q,     rel_d;      // make-code frame still pending after break
  logic        ready_q,   ready_d;
  logic        clk_q,     clk_d;
  logic        dat_q,     dat_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

  ps2_tx_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign send_ready = ready_q;
  assign PS2Clk     = clk_q;
  assign PS2Data    = dat_q;

  // Frame sequencing: next state, next line levels and timer reloads.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    scan_d    = scan_q;
    rel_d     = rel_q;
    ready_d   = ready_q;
    clk_d     = clk_q;
    dat_d     = dat_q;
    tmr_load  = 1'b0;
    tmr_val   = HP_LOAD;
    case (state_q)
      IDLE: begin
        if (send_valid && ready_q) begin
          scan_d    = scancode;
          rel_d     = send_release;
          data_d    = send_release ? BREAK_CODE : scancode;
          bit_cnt_d = 4'd0;
          dat_d     = 1'b0;            // start bit
          clk_d     = 1'b1;
          ready_d   = 1'b0;
          state_d   = BIT_HI;
          tmr_load  = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      BIT_HI: begin
        if (tmr_tc) begin
          clk_d    = 1'b0;
          state_d  = BIT_LO;
          tmr_load = 1'b1;
        end else begin
          clk_d = 1'b1;
        end
      end
      BIT_LO: begin
        if (tmr_tc && (bit_cnt_q == LAST_BIT)) begin
          clk_d    = 1'b1;
          dat_d    = 1'b1;
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else if (tmr_tc) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          dat_d     = frame_bit(data_q, bit_cnt_q + 4'd1);
          clk_d     = 1'b1;
          state_d   = BIT_HI;
          tmr_load  = 1'b1;
        end else begin
          clk_d = 1'b0;
        end
      end
      GAP: begin
        if (tmr_tc && rel_q) begin
          rel_d     = 1'b0;
          data_d    = scan_q;
          bit_cnt_d = 4'd0;
          dat_d     = 1'b0;            // start bit of the make-code frame
          state_d   = BIT_HI;
          tmr_load  = 1'b1;
        end else if (tmr_tc) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        clk_d   = 1'b1;
        dat_d   = 1'b1;
      end
    endcase
  end

  // State and registered line outputs; reset returns both lines high at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      scan_q    <= 8'h00;
      rel_q     <= 1'b0;
      ready_q   <= 1'b1;
      clk_q     <= 1'b1;
      dat_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      scan_q    <= scan_d;
      rel_q     <= rel_d;
      ready_q   <= ready_d;
      clk_q     <= clk_d;
      dat_q     <= dat_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Scoreboard bench for ps2_keyboard_tx: stimulus pushes expected 11-bit
// frames, a line monitor decodes PS2Clk/PS2Data and checks frames and timing.
module tb_ps2_keyboard_tx;

  localparam int HP = 4;
  localparam int GP = 8;

  localparam logic [10:0] F_17 = 11'b11000101110;
  localparam logic [10:0] F_F0 = 11'b11111100000;
  localparam logic [10:0] F_16 = 11'b10000101100;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] scancode;
  logic       send_release;
  logic       send_valid;
  logic       send_ready;
  logic       PS2Clk;
  logic       PS2Data;

  int total = 0;
  int bad   = 0;

  logic [10:0] exp_q[$];
  int  mon_nbits   = 0;
  int  mon_falls   = 0;
  int  mon_last_gap = 0;
  longint t_acc = 0;

  always #5 clk = ~clk;

  ps2_keyboard_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GP)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .scancode     (scancode),
    .send_release (send_release),
    .send_valid   (send_valid),
    .send_ready   (send_ready),
    .PS2Clk       (PS2Clk),
    .PS2Data      (PS2Data)
  );

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    f[10]  = 1'b1;
    return f;
  endfunction

  // Line monitor and frame checker.
  initial begin
    logic        prev_clk;
    logic        held;
    logic        in_gap;
    logic [10:0] bits;
    int lo_run, hi_run, st_run, gap;
    prev_clk = 1'b1; held = 1'b1; in_gap = 1'b0; bits = 11'd0;
    lo_run = 0; hi_run = 0; st_run = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("reset_ps2clk", int'(PS2Clk), 1);
        chk("reset_ps2data", int'(PS2Data), 1);
        chk("reset_ready", int'(send_ready), 1);
        exp_q.delete();
        mon_nbits = 0; prev_clk = 1'b1; in_gap = 1'b0;
        lo_run = 0; hi_run = 0; st_run = 0; gap = 0;
      end else begin
        if (prev_clk && !PS2Clk) begin
          if (mon_nbits == 0) chk("first_half_period", st_run, HP);
          else                chk("high_half_period", hi_run, HP);
          bits[mon_nbits] = PS2Data;
          held = PS2Data;
          lo_run = 1;
          mon_falls++;
          mon_nbits++;
          if (mon_nbits == 11) begin
            chk("frame_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("frame_bits", int'(bits), int'(exp_q.pop_front()));
            mon_nbits = 0;
            in_gap = 1'b1;
            gap = 0;
          end
        end else if (!PS2Clk) begin
          lo_run++;
          chk("data_stable_low", int'(PS2Data), int'(held));
        end else if (!prev_clk) begin
          chk("low_half_period", lo_run, HP);
          hi_run = 1;
        end else begin
          hi_run++;
        end
        if (PS2Clk && mon_nbits == 0) begin
          if (PS2Data) begin
            if (in_gap) gap++;
            st_run = 0;
          end else begin
            if (in_gap) begin
              mon_last_gap = gap;
              chk("gap_min", int'(gap >= GP), 1);
              in_gap = 1'b0;
            end
            st_run++;
          end
        end
        prev_clk = PS2Clk;
      end
    end
  end

  // Handshake one request; called on a negedge.
  task automatic accept(input logic [7:0] code, input logic rel);
    int n = 0;
    while (!send_ready && n < 1000) begin @(negedge clk); n++; end
    chk("ready_before_send", int'(send_ready), 1);
    scancode = code; send_release = rel; send_valid = 1'b1;
    @(posedge clk);
    t_acc = longint'($time);
    @(negedge clk);
    send_valid = 1'b0;
    chk("start_bit_next_cycle", int'(PS2Data), 0);
    chk("clk_high_at_start", int'(PS2Clk), 1);
    chk("ready_low_busy", int'(send_ready), 0);
  endtask

  // Wait (bounded) for send_ready and check the busy time from accept.
  task automatic wait_idle(input int cyc);
    int n = 0;
    while (!send_ready && n < 1000) begin @(negedge clk); n++; end
    chk("busy_cycles", int'((longint'($time) - t_acc) / 10), cyc);
  endtask

  // Global bound on the run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int n, f0;
    logic [7:0] c;
    logic r;
    rstn = 1'b0; send_valid = 1'b0; send_release = 1'b0; scancode = 8'h00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Make 0x17, requested on the first edge after reset release.
    exp_q.push_back(F_17);
    accept(8'h17, 1'b0);
    wait_idle(96);

    // Break 0x17: F0 frame, gap, then 0x17 frame.
    f0 = mon_falls;
    exp_q.push_back(F_F0);
    exp_q.push_back(F_17);
    accept(8'h17, 1'b1);
    wait_idle(192);
    chk("break_fall_count", mon_falls - f0, 22);
    chk("break_inner_gap", mon_last_gap, GP);

    // Make 0x16 (parity 0).
    exp_q.push_back(F_16);
    accept(8'h16, 1'b0);
    wait_idle(96);

    // send_valid held high through a frame with 0x1C.
    exp_q.push_back(F_17);
    scancode = 8'h17; send_release = 1'b0; send_valid = 1'b1;
    @(posedge clk);
    t_acc = longint'($time);
    @(negedge clk);
    scancode = 8'h1C;
    n = 0;
    while (!send_ready && n < 1000) begin @(negedge clk); n++; end
    chk("held_valid_busy", int'((longint'($time) - t_acc) / 10), 96);
    exp_q.push_back(frame_of(8'h1C));
    @(posedge clk);
    t_acc = longint'($time);
    @(negedge clk);
    send_valid = 1'b0;
    chk("held_valid_accept", int'(send_ready), 0);
    chk("held_valid_start", int'(PS2Data), 0);
    wait_idle(96);

    // Reset after the 5th falling edge, then a clean frame.
    exp_q.push_back(F_17);
    accept(8'h17, 1'b0);
    n = 0;
    while (mon_nbits != 5 && n < 200) begin @(negedge clk); n++; end
    chk("reached_fifth_fall", mon_nbits, 5);
    #1 rstn = 1'b0;
    #1;
    chk("abort_ps2clk", int'(PS2Clk), 1);
    chk("abort_ps2data", int'(PS2Data), 1);
    chk("abort_ready", int'(send_ready), 1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_q.push_back(F_17);
    accept(8'h17, 1'b0);
    wait_idle(96);

    // Randomized requests with ignored send_valid pulses while busy.
    for (int i = 0; i < 10; i++) begin
      c = 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 2) == 0);
      if (r) exp_q.push_back(frame_of(8'hF0));
      exp_q.push_back(frame_of(c));
      accept(c, r);
      repeat ($urandom_range(5, 30)) @(negedge clk);
      scancode = 8'($urandom_range(0, 255));
      send_valid = 1'b1;
      repeat (3) @(negedge clk);
      send_valid = 1'b0;
      wait_idle(r ? 192 : 96);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", int'(exp_q.size()), 0);
    chk("no_partial_frame", mon_nbits, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
